// File: rtl/cgra_ctrl_loader_if.sv
// cgra_ctrl_loader_if: host, config and tile-side signals of the control loader
interface cgra_ctrl_loader_if #(
  parameter int NUM_TILES     = 4,
  parameter int CTRL_MEM_SIZE = 4,
  parameter int CTRL_W        = 49,
  parameter int RUN_W         = 16
);
  localparam int ADDR_W = $clog2(CTRL_MEM_SIZE);
  logic                 cfg_start__en;
  logic [RUN_W-1:0]     cfg_start__msg;
  logic                 cfg_start__rdy;
  logic                 recv_ctrl__en;
  logic [CTRL_W-1:0]    recv_ctrl__msg;
  logic                 recv_ctrl__rdy;
  logic [CTRL_W-1:0]    tile_ctrl__msg;
  logic [ADDR_W-1:0]    tile_waddr__msg;
  logic [NUM_TILES-1:0] tile_wen;
  logic                 cgra_run;
  logic                 done__en;
  logic                 done__rdy;
  logic                 abort;
  logic [2:0]           state_o;
  modport slave (
    input  cfg_start__en, cfg_start__msg, recv_ctrl__en, recv_ctrl__msg, done__rdy, abort,
    output cfg_start__rdy, recv_ctrl__rdy, tile_ctrl__msg, tile_waddr__msg, tile_wen,
           cgra_run, done__en, state_o
  );
  modport master (
    output cfg_start__en, cfg_start__msg, recv_ctrl__en, recv_ctrl__msg, done__rdy, abort,
    input  cfg_start__rdy, recv_ctrl__rdy, tile_ctrl__msg, tile_waddr__msg, tile_wen,
           cgra_run, done__en, state_o
  );
endinterface

// File: rtl/cgra_ctrl_loader.sv
// cgra_ctrl_loader: streams config words into tile CtrlMems, then runs the CGRA for a set cycle count
module cgra_ctrl_loader #(
  parameter int NUM_TILES     = 4,
  parameter int CTRL_MEM_SIZE = 4,
  parameter int CTRL_W        = 49,
  parameter int RUN_W         = 16
) (
  input logic              clk,
  input logic              reset,
  cgra_ctrl_loader_if.slave bus
);
  localparam int ADDR_W = $clog2(CTRL_MEM_SIZE);
  localparam int TILE_W = $clog2(NUM_TILES);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, FLUSH = 3'd2, RUN = 3'd3, DONE = 3'd4} state_t;
  state_t               state_q, state_d;
  logic [TILE_W-1:0]    tile_q, tile_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0]     run_len_q, run_len_d;
  logic [NUM_TILES-1:0] wen_q, wen_d;
  logic [CTRL_W-1:0]    wmsg_q, wmsg_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic                 addr_end, tile_end;
  assign addr_end = addr_q == ADDR_W'(CTRL_MEM_SIZE - 1);
  assign tile_end = tile_q == TILE_W'(NUM_TILES - 1);
  assign bus.cfg_start__rdy  = state_q == IDLE;
  assign bus.recv_ctrl__rdy  = state_q == LOAD;
  assign bus.cgra_run        = state_q == RUN;
  assign bus.done__en        = state_q == DONE;
  assign bus.tile_wen        = wen_q;
  assign bus.tile_ctrl__msg  = wmsg_q;
  assign bus.tile_waddr__msg = waddr_q;
  assign bus.state_o         = state_q;
  // state and write-pulse registers; write data/address hold their last value between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      addr_q    <= '0;
      run_cnt_q <= '0;
      run_len_q <= '0;
      wen_q     <= '0;
      wmsg_q    <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      addr_q    <= addr_d;
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
      wen_q     <= wen_d;
      wmsg_q    <= wmsg_d;
      waddr_q   <= waddr_d;
    end
  end
  // next-state: abort wins over everything, a word seen with abort is dropped
  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    addr_d    = addr_q;
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
    wen_d     = '0;
    wmsg_d    = wmsg_q;
    waddr_d   = waddr_q;
    if (bus.abort) begin
      state_d   = IDLE;
      tile_d    = '0;
      addr_d    = '0;
      run_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cfg_start__en) begin
          run_len_d = bus.cfg_start__msg;
          tile_d    = '0;
          addr_d    = '0;
          state_d   = LOAD;
        end
        LOAD: if (bus.recv_ctrl__en) begin
          wen_d[tile_q] = 1'b1;
          waddr_d       = addr_q;
          wmsg_d        = bus.recv_ctrl__msg;
          addr_d        = addr_end ? '0 : addr_q + 1'b1;
          tile_d        = !addr_end ? tile_q : tile_end ? '0 : tile_q + 1'b1;
          state_d       = addr_end && tile_end ? FLUSH : LOAD;
        end
        FLUSH: state_d = run_len_q == '0 ? DONE : RUN;
        RUN: begin
          run_cnt_d = run_cnt_q == run_len_q - RUN_W'(1) ? '0 : run_cnt_q + 1'b1;
          state_d   = run_cnt_q == run_len_q - RUN_W'(1) ? DONE : RUN;
        end
        DONE: state_d = bus.done__rdy ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cgra_ctrl_loader.sv
// tb_cgra_ctrl_loader: word-count model of the loader checked every cycle, plus hand-computed pins
module tb_cgra_ctrl_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cgra_ctrl_loader_if #(.NUM_TILES(4), .CTRL_MEM_SIZE(4), .CTRL_W(49), .RUN_W(16)) bus ();
  cgra_ctrl_loader #(.NUM_TILES(4), .CTRL_MEM_SIZE(4), .CTRL_W(49), .RUN_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle,1 load,2 flush,3 run,4 done; k = words accepted this session
  int phase, k, left, run_len;
  logic [3:0]  e_wen;
  logic [1:0]  e_addr;
  logic [48:0] e_msg;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0; k = 0; left = 0; run_len = 0; e_wen = 0; e_addr = 0; e_msg = 0;
    end else begin
      e_wen = 0;
      if (bus.abort) begin
        phase = 0; k = 0; left = 0;
      end else if (phase == 0) begin
        if (bus.cfg_start__en) begin run_len = int'(bus.cfg_start__msg); k = 0; phase = 1; end
      end else if (phase == 1) begin
        if (bus.recv_ctrl__en) begin
          e_wen = 4'(1 << (k / 4)); e_addr = 2'(k % 4); e_msg = bus.recv_ctrl__msg;
          k++;
          if (k == 16) phase = 2;
        end
      end else if (phase == 2) begin
        left = run_len; phase = run_len == 0 ? 4 : 3;
      end else if (phase == 3) begin
        left--;
        if (left == 0) phase = 4;
      end else if (phase == 4) begin
        if (bus.done__rdy) phase = 0;
      end
    end
  end
  int wr_cnt = 0;
  int run_hi = 0;
  logic [3:0]  wr_wen  [256];
  logic [1:0]  wr_addr [256];
  logic [48:0] wr_msg  [256];
  // per-cycle comparison and a log of observed writes/run cycles
  always @(negedge clk) begin
    if (!reset) begin
      chk("state_o", 64'(bus.state_o), 64'(phase));
      chk("cfg_start_rdy", 64'(bus.cfg_start__rdy), 64'(phase == 0));
      chk("recv_ctrl_rdy", 64'(bus.recv_ctrl__rdy), 64'(phase == 1));
      chk("cgra_run", 64'(bus.cgra_run), 64'(phase == 3));
      chk("done_en", 64'(bus.done__en), 64'(phase == 4));
      chk("tile_wen", 64'(bus.tile_wen), 64'(e_wen));
      if (e_wen != 0) begin
        chk("tile_waddr", 64'(bus.tile_waddr__msg), 64'(e_addr));
        chk("tile_ctrl", 64'(bus.tile_ctrl__msg), 64'(e_msg));
      end
      if (bus.tile_wen != 0 && wr_cnt < 256) begin
        wr_wen[wr_cnt] = bus.tile_wen; wr_addr[wr_cnt] = bus.tile_waddr__msg;
        wr_msg[wr_cnt] = bus.tile_ctrl__msg; wr_cnt++;
      end
      if (bus.cgra_run) run_hi++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input int len);
    bus.cfg_start__en = 1'b1; bus.cfg_start__msg = 16'(len);
    tick();
    bus.cfg_start__en = 1'b0;
  endtask
  task automatic load(input int base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      bus.recv_ctrl__en = 1'b1; bus.recv_ctrl__msg = 49'(base + i);
      tick();
      if (gap) begin bus.recv_ctrl__en = 1'b0; tick(); end
    end
    bus.recv_ctrl__en = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 64 && !bus.done__en; i++) tick();
    chk("done_timeout", 64'(bus.done__en), 64'd1);
  endtask
  task automatic ack();
    bus.done__rdy = 1'b1;
    tick();
    bus.done__rdy = 1'b0;
  endtask
  int wb, rb;
  initial begin
    reset = 1'b1;
    bus.cfg_start__en = 0; bus.cfg_start__msg = 0; bus.recv_ctrl__en = 0;
    bus.recv_ctrl__msg = 0; bus.done__rdy = 0; bus.abort = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    // full load, run 5
    wb = wr_cnt; rb = run_hi;
    start(5); load('h100, 16, 0); wait_done();
    chk("t2_writes", 64'(wr_cnt - wb), 64'd16);
    chk("t2_run_cycles", 64'(run_hi - rb), 64'd5);
    chk("t2_w5_wen", 64'(wr_wen[wb + 5]), 64'h2);
    chk("t2_w5_addr", 64'(wr_addr[wb + 5]), 64'd1);
    chk("t2_w5_msg", 64'(wr_msg[wb + 5]), 64'h105);
    chk("t2_w15_wen", 64'(wr_wen[wb + 15]), 64'h8);
    chk("t2_w15_addr", 64'(wr_addr[wb + 15]), 64'd3);
    ack();
    // done held without ack
    start(1); load('h300, 16, 0); wait_done();
    bus.done__rdy = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_held_state", 64'(bus.state_o), 64'd4);
    chk("t5_held_done", 64'(bus.done__en), 64'd1);
    ack();
    chk("t5_idle_state", 64'(bus.state_o), 64'd0);
    chk("t5_start_rdy", 64'(bus.cfg_start__rdy), 64'd1);
    // gapped load, run 3
    wb = wr_cnt; rb = run_hi;
    start(3); load('h400, 16, 1); wait_done();
    chk("t3_writes", 64'(wr_cnt - wb), 64'd16);
    chk("t3_run_cycles", 64'(run_hi - rb), 64'd3);
    chk("t3_w9_wen", 64'(wr_wen[wb + 9]), 64'h4);
    chk("t3_w9_addr", 64'(wr_addr[wb + 9]), 64'd1);
    chk("t3_w9_msg", 64'(wr_msg[wb + 9]), 64'h409);
    ack();
    // zero-length run
    wb = wr_cnt; rb = run_hi;
    start(0); load('h500, 16, 0);
    chk("t4_flush_state", 64'(bus.state_o), 64'd2);
    tick();
    chk("t4_done_state", 64'(bus.state_o), 64'd4);
    chk("t4_run_cycles", 64'(run_hi - rb), 64'd0);
    chk("t4_writes", 64'(wr_cnt - wb), 64'd16);
    ack();
    // abort while word 7 is presented
    wb = wr_cnt;
    start(7); load('h600, 7, 0);
    bus.recv_ctrl__en = 1'b1; bus.recv_ctrl__msg = 49'h607; bus.abort = 1'b1;
    tick();
    bus.recv_ctrl__en = 1'b0; bus.abort = 1'b0;
    chk("t6_abort_state", 64'(bus.state_o), 64'd0);
    chk("t6_abort_wen", 64'(bus.tile_wen), 64'd0);
    chk("t6_writes", 64'(wr_cnt - wb), 64'd7);
    wb = wr_cnt;
    start(2); load('h200, 16, 0); wait_done();
    chk("t6_w0_wen", 64'(wr_wen[wb]), 64'h1);
    chk("t6_w0_addr", 64'(wr_addr[wb]), 64'd0);
    chk("t6_w0_msg", 64'(wr_msg[wb]), 64'h200);
    ack();
    // asynchronous reset mid-run
    start(20); load('h700, 16, 0);
    for (int i = 0; i < 8 && !bus.cgra_run; i++) tick();
    chk("t1_running", 64'(bus.cgra_run), 64'd1);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("t1_run", 64'(bus.cgra_run), 64'd0);
    chk("t1_wen", 64'(bus.tile_wen), 64'd0);
    chk("t1_done", 64'(bus.done__en), 64'd0);
    chk("t1_state", 64'(bus.state_o), 64'd0);
    chk("t1_msg", 64'(bus.tile_ctrl__msg), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
